// File: rtl/nv_ram_pkg.sv
// Shared types and helpers for the nv_ram_rws_pipe family of register-file RAMs.
// Holds the init-sweep state encoding, the address-width helper and the write-mask merge.
package nv_ram_pkg;

    localparam int MAX_W   = 1024;
    localparam int MAX_SEG = 1024;
    localparam int IDX_W   = 10;

    typedef enum logic {
        INIT,
        READY
    } init_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Bit i comes from new_word when its segment (i / gran) is enabled in mask.
    function automatic logic [MAX_W-1:0] seg_merge(
        input logic [MAX_W-1:0]   old_word,
        input logic [MAX_W-1:0]   new_word,
        input logic [MAX_SEG-1:0] mask,
        input int                 gran
    );
        logic [MAX_W-1:0] result;
        result = old_word;
        for (int i = 0; i < MAX_W; i++) begin
            if (mask[IDX_W'(i / gran)]) begin
                result[IDX_W'(i)] = new_word[IDX_W'(i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/nv_ram_init_seq.sv
// Post-reset clear sweep: writes zero to every entry, then raises init_done.
// A reset during the sweep restarts it from entry 0.
module nv_ram_init_seq
    import nv_ram_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_init_done,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    init_state_t   r_state;
    init_state_t   w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_init_done = 1'b0;
        o_clr_we    = 1'b0;
        o_clr_addr  = r_cnt;
        case (r_state)
            INIT: begin
                o_clr_we = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = READY;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            READY: begin
                o_init_done = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/nv_ram_rws_pipe.sv
// One-read/one-write synchronous register-file RAM with segment write masks,
// selectable read-during-write behaviour, optional output register and clear sweep.
module nv_ram_rws_pipe
    import nv_ram_pkg::*;
#(
    parameter int  DEPTH     = 64,
    parameter int  WIDTH     = 116,
    parameter int  MASK_GRAN = 116,
    parameter int  OUT_REG   = 0,
    parameter int  BYPASS    = 1,
    parameter int  INIT_CLR  = 0,
    localparam int AW        = clog2(DEPTH),
    localparam int NSEG      = WIDTH / MASK_GRAN
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [NSEG-1:0]  wmask,
    input  logic [WIDTH-1:0] di,
    output logic             init_done,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam bit          USE_BYP = (BYPASS != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_vld;

    logic             w_init_done;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    logic             w_wa_ok;
    logic             w_ra_ok;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_collide;
    logic [WIDTH-1:0] w_wr_word;
    logic [WIDTH-1:0] w_rd_byp;
    logic [WIDTH-1:0] w_rd_word;
    logic             w_unused_pwrbus;

    assign w_unused_pwrbus = ^pwrbus_ram_pd;

    generate
        if (INIT_CLR != 0) begin : g_init
            nv_ram_init_seq #(
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_init_seq (
                .i_clk       (nvdla_core_clk),
                .i_rst_n     (nvdla_core_rstn),
                .o_init_done (w_init_done),
                .o_clr_we    (w_clr_we),
                .o_clr_addr  (w_clr_addr)
            );
        end else begin : g_no_init
            assign w_init_done = 1'b1;
            assign w_clr_we    = 1'b0;
            assign w_clr_addr  = '0;
        end
    endgenerate

    assign init_done = w_init_done;

    // Out-of-range addresses only occur when DEPTH is not a power of two.
    assign w_wa_ok   = ({1'b0, wa} < DEPTH_L);
    assign w_ra_ok   = ({1'b0, ra} < DEPTH_L);
    assign w_wr_acc  = we & w_init_done & w_wa_ok;
    assign w_rd_acc  = re & w_init_done;
    assign w_collide = w_rd_acc & w_wr_acc & w_ra_ok & (ra == wa);

    assign w_wr_word = WIDTH'(seg_merge(MAX_W'(r_mem[wa]), MAX_W'(di),
                                        MAX_SEG'(wmask), MASK_GRAN));
    assign w_rd_byp  = WIDTH'(seg_merge(MAX_W'(r_mem[ra]), MAX_W'(di),
                                        MAX_SEG'(wmask), MASK_GRAN));

    always_comb begin
        w_rd_word = '0;
        if (w_ra_ok) begin
            w_rd_word = r_mem[ra];
            if (USE_BYP && w_collide) begin
                w_rd_word = w_rd_byp;
            end
        end
    end

    // NOTE: the storage array has no reset branch; clearing it is the job of
    // the optional init sweep, and a reset on every entry would cost a flop
    // reset net per bit for no functional gain.
    always_ff @(posedge nvdla_core_clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[wa] <= w_wr_word;
        end
    end

    // Read stage holds its data when no read is accepted.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] r_out_data;
            logic             r_out_vld;

            always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
                if (!nvdla_core_rstn) begin
                    r_out_data <= '0;
                    r_out_vld  <= 1'b0;
                end else begin
                    r_out_vld <= r_rd_vld;
                    if (r_rd_vld) begin
                        r_out_data <= r_rd_data;
                    end
                end
            end

            assign dout     = r_out_data;
            assign dout_vld = r_out_vld;
        end else begin : g_no_out_reg
            assign dout     = r_rd_data;
            assign dout_vld = r_rd_vld;
        end
    endgenerate

endmodule
